ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Reader side of the program-counter interface.
- Consumes the current PC value, fetches instruction words from instruction memory over a req/ack handshake, and buffers them in a small queue feeding the IF/ID register.
- Drives the PC write-enable back to the PC register, so the PC advances only when a fetch has been accepted or a redirect occurs.

Parameters:
- ADDR_W, 32, PC / memory address width.
- DATA_W, 32, instruction word width.
- QDEPTH, 2, instruction queue depth (power of two, >=2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-low
- start_i  in  1  CPU run enable; no new fetch is issued while low
- pc_i  in  ADDR_W  current PC register value
- pc_write_o  out  1  PC write-enable to the PC register
- flush_i  in  1  branch/jump redirect; PC mux presents the target this cycle
- mem_req_o  out  1  instruction memory request
- mem_addr_o  out  ADDR_W  request address, word aligned
- mem_ack_i  in  1  memory accepts the request; data valid this cycle
- mem_data_i  in  DATA_W  fetched instruction
- inst_o  out  DATA_W  queue head instruction
- inst_pc_o  out  ADDR_W  address of inst_o
- inst_valid_o  out  1  queue non-empty
- id_stall_i  in  1  IF/ID hold; head is not consumed

Behaviour:
- Reset (rst_i low, asynchronous) forces:
  - state IDLE, queue count 0, pointers 0, addr_q 0;
  - mem_req_o 0, inst_valid_o 0, inst_o 0, inst_pc_o 0;
  - pc_write_o 0 regardless of flush_i.
- FSM states: IDLE, REQ, DROP.
- IDLE:
  - mem_req_o=0.
  - If start_i & !flush_i & count<QDEPTH: addr_q<=pc_i, go to REQ.
- REQ:
  - mem_req_o=1, mem_addr_o={addr_q[ADDR_W-1:2],2'b00}, held stable until mem_ack_i.
  - Zero-wait ack (in the first REQ cycle) is legal.
- Accepted fetch (REQ & mem_ack_i & !flush_i):
  - push {addr_q, mem_data_i} into the queue;
  - pc_write_o=1 combinationally, so the PC register loads pc+4 at this edge;
  - addr_q<=addr_q+4.
  - Stay in REQ if start_i and the post-edge count <QDEPTH, else go to IDLE.
  - Result: 1 instruction/cycle with zero-wait memory.
- pc_write_o = flush_i | (state==REQ & mem_ack_i & !flush_i); otherwise 0. PC holds.
- Queue pop: inst_valid_o & !id_stall_i, at the clock edge. Push and pop in the same cycle leave count unchanged.
- Issue throttle: no request is started while the queue would be full after the edge, so an ack can never arrive when the queue is full.
- inst_o / inst_pc_o:
  - show the queue head;
  - are 0 (NOP) when the queue is empty.
- flush_i (priority over push and pop):
  - queue cleared;
  - inst_valid_o=0 the next cycle;
  - pc_write_o=1.
  - In REQ without ack: go to DROP.
  - In REQ with ack: data discarded, go to IDLE.
  - In IDLE: stay in IDLE.
- DROP:
  - mem_req_o held high with the old addr_q until mem_ack_i;
  - data discarded, no pc_write_o from the ack, then go to IDLE.
  - flush_i in DROP: clear the queue, pulse pc_write_o, stay in DROP.
- start_i low mid-REQ: the outstanding request completes and is pushed, then go to IDLE.
- addr_q+4 wraps modulo 2^ADDR_W.

Decomposition:
- Shared package (ifetch_pkg):
  - FSM state encodings IDLE/REQ/DROP;
  - NOP instruction constant 32'h00000000;
  - WORD_BYTES=4.
- One sub-module, inst_fifo: synchronous FIFO of {pc, inst} with push, pop, flush, count, full/empty. Flush has priority.

Test Plan:
- Reset, start_i=1, pc_i=0, ack tied to req, no stall -> mem_addr_o 0x0, 0x4, 0x8 on consecutive cycles; pc_write_o=1 each cycle; inst_valid_o=1 with inst_pc_o=0x0 one cycle after the first ack.
- id_stall_i held high, zero-wait memory -> exactly 2 acks, then mem_req_o=0 and pc_write_o=0; release stall -> head pops and fetching resumes at 0x8.
- Ack latency 3 cycles at pc 0x20 -> mem_req_o and mem_addr_o=0x20 stable for 3 cycles; pc_write_o=1 only in the ack cycle; inst_pc_o=0x20 next cycle.
- flush_i while a request at 0x10 is outstanding, ack 2 cycles later, pc_i=0x40 after flush:
  - pc_write_o=1 in the flush cycle;
  - queue empties;
  - 0x10 request held until ack, its data never appears;
  - next request is at 0x40.
- flush_i coincident with ack and pop -> no push; inst_valid_o=0 next cycle; state IDLE.
- rst_i low asynchronously mid-REQ -> mem_req_o, inst_valid_o, pc_write_o all 0 immediately; after release, first request is at the then-current pc_i.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Imported by the fetch FSM top and its instruction queue.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST   = 32'h0000_0000;
    localparam int          WORD_BYTES = 4;

    // Clear the byte-offset bits of a fetch address.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_inst_fifo.sv
// Small synchronous queue of {pc, instruction} pairs.
// Flush wins over push and pop in the same cycle.
module inst_fifo #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [AW-1:0] push_pc_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [AW-1:0] head_pc_o,
    output logic [DW-1:0] head_data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [AW-1:0] pc_mem   [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign do_push     = push_i & ~full_o & ~flush_i;
    assign do_pop      = pop_i & ~empty_o & ~flush_i;
    assign head_pc_o   = pc_mem[rd_ptr_q];
    assign head_data_o = data_mem[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush empties the queue.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; entries need no reset since empty masks the head.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            pc_mem[wr_ptr_q]   <= push_pc_i;
            data_mem[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: reads the PC, fetches over req/ack and
// queues words for IF/ID, advancing the PC only on accepted fetches.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int QDEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_write_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              id_stall_i
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_data;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              full;
    logic              empty;
    logic              ack_ok;
    logic              pop;
    logic              can_issue;
    logic              keep_going;

    assign ack_ok     = (state_q == REQ) & mem_ack_i & ~flush_i;
    assign pop        = ~empty & ~id_stall_i;
    assign count_nxt  = count + CW'(ack_ok) - CW'(pop);
    assign can_issue  = start_i & ~flush_i & (count < CW'(QDEPTH));
    assign keep_going = start_i & (count_nxt < CW'(QDEPTH));

    // Redirects always load the PC; reset masks a stray flush.
    assign pc_write_o   = rst_i & (flush_i | ack_ok);
    assign mem_req_o    = (state_q != IDLE);
    assign mem_addr_o   = {addr_q[ADDR_W-1:2], 2'b00};
    assign inst_valid_o = ~empty;
    assign inst_o       = empty ? DATA_W'(NOP_INST) : head_data;
    assign inst_pc_o    = empty ? '0 : head_pc;

    inst_fifo #(
        .AW    (ADDR_W),
        .DW    (DATA_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (ack_ok),
        .push_pc_i   (addr_q),
        .push_data_i (mem_data_i),
        .pop_i       (pop),
        .head_pc_o   (head_pc),
        .head_data_o (head_data),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    // Fetch sequencer: issue, hold request until ack, drop on redirect.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (can_issue) begin
                        addr_q  <= pc_i;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        state_q <= mem_ack_i ? IDLE : DROP;
                    end else if (mem_ack_i) begin
                        addr_q  <= addr_q + ADDR_W'(WORD_BYTES);
                        state_q <= keep_going ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (mem_ack_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Full is implied by the issue throttle; kept for visibility only.
    logic unused_full;
    assign unused_full = full;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a small PC-register model
// and an instruction memory that returns addr ^ 0xA5A50000.
module tb_ifetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] pc_i;
    logic        pc_write_o;
    logic        flush_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        id_stall_i = 1'b0;

    logic        ack_auto = 1'b1;
    logic        ack_man = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_seed = '0;
    logic [31:0] tgt = '0;
    logic [31:0] pc_q = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          acks;

    always #5 clk_i = ~clk_i;

    assign pc_i       = pc_q;
    assign mem_ack_i  = ack_auto ? mem_req_o : ack_man;
    assign mem_data_i = mem_addr_o ^ 32'hA5A5_0000;

    // PC register: flush loads the target, otherwise pc+4.
    always @(posedge clk_i) begin
        if (pc_load)
            pc_q <= pc_seed;
        else if (pc_write_o)
            pc_q <= flush_i ? tgt : pc_q + 32'd4;
    end

    ifetch_unit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .pc_i         (pc_i),
        .pc_write_o   (pc_write_o),
        .flush_i      (flush_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .id_stall_i   (id_stall_i)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk_i);
    endtask

    // Hold reset one cycle while seeding the PC, release with start=1.
    task automatic do_reset(input logic [31:0] seed, input logic aa);
        rst_i    = 1'b0;
        start_i  = 1'b0;
        flush_i  = 1'b0;
        ack_man  = 1'b0;
        ack_auto = aa;
        pc_load  = 1'b1;
        pc_seed  = seed;
        nxt();
        pc_load  = 1'b0;
        rst_i    = 1'b1;
        start_i  = 1'b1;
    endtask

    initial begin
        // Reset state
        nxt();
        flush_i = 1'b1;
        #1;
        chk("rst_req", 32'(mem_req_o), 0);
        chk("rst_pw_flush", 32'(pc_write_o), 0);
        chk("rst_valid", 32'(inst_valid_o), 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_ipc", inst_pc_o, 0);

        // Streaming with zero-wait memory
        nxt();
        do_reset(32'h0, 1'b1);
        #1 chk("t1_c0_req", 32'(mem_req_o), 0);
        nxt(); #1;
        chk("t1_c1_req", 32'(mem_req_o), 1);
        chk("t1_c1_addr", mem_addr_o, 32'h0);
        chk("t1_c1_pw", 32'(pc_write_o), 1);
        chk("t1_c1_valid", 32'(inst_valid_o), 0);
        nxt(); #1;
        chk("t1_c2_addr", mem_addr_o, 32'h4);
        chk("t1_c2_pw", 32'(pc_write_o), 1);
        chk("t1_c2_valid", 32'(inst_valid_o), 1);
        chk("t1_c2_ipc", inst_pc_o, 32'h0);
        chk("t1_c2_inst", inst_o, 32'hA5A5_0000);
        nxt(); #1;
        chk("t1_c3_addr", mem_addr_o, 32'h8);
        chk("t1_c3_pw", 32'(pc_write_o), 1);
        chk("t1_c3_ipc", inst_pc_o, 32'h4);

        // Stall fills the queue, then release resumes at 0x8
        nxt();
        id_stall_i = 1'b1;
        do_reset(32'h0, 1'b1);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            #1 if (mem_req_o && mem_ack_i) acks++;
            nxt();
        end
        id_stall_i = 1'b0;
        #1;
        chk("t2_acks", 32'(acks), 2);
        chk("t2_req", 32'(mem_req_o), 0);
        chk("t2_pw", 32'(pc_write_o), 0);
        chk("t2_pc", pc_q, 32'h8);
        chk("t2_ipc0", inst_pc_o, 32'h0);
        nxt(); #1;
        chk("t2_d1_req", 32'(mem_req_o), 0);
        chk("t2_d1_ipc", inst_pc_o, 32'h4);
        nxt(); #1;
        chk("t2_d2_req", 32'(mem_req_o), 1);
        chk("t2_d2_addr", mem_addr_o, 32'h8);
        chk("t2_d2_pw", 32'(pc_write_o), 1);
        chk("t2_d2_valid", 32'(inst_valid_o), 0);

        // Three-cycle ack latency, then start drops mid-request
        nxt();
        do_reset(32'h20, 1'b0);
        nxt();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t3_wait_req", 32'(mem_req_o), 1);
            chk("t3_wait_addr", mem_addr_o, 32'h20);
            chk("t3_wait_pw", 32'(pc_write_o), 0);
            nxt();
        end
        ack_man = 1'b1;
        #1;
        chk("t3_ack_addr", mem_addr_o, 32'h20);
        chk("t3_ack_pw", 32'(pc_write_o), 1);
        nxt();
        ack_man = 1'b0;
        start_i = 1'b0;
        #1;
        chk("t3_c4_ipc", inst_pc_o, 32'h20);
        chk("t3_c4_addr", mem_addr_o, 32'h24);
        chk("t3_c4_pw", 32'(pc_write_o), 0);
        nxt();
        ack_man = 1'b1;
        #1 chk("t3_c5_pw", 32'(pc_write_o), 1);
        nxt();
        ack_man = 1'b0;
        #1;
        chk("t3_c6_req", 32'(mem_req_o), 0);
        chk("t3_c6_ipc", inst_pc_o, 32'h24);
        chk("t3_c6_inst", inst_o, 32'hA5A5_0024);
        nxt(); #1;
        chk("t3_c7_valid", 32'(inst_valid_o), 0);
        chk("t3_c7_inst", inst_o, 32'h0);
        chk("t3_c7_ipc", inst_pc_o, 32'h0);

        // Flush with a request outstanding: drop it, refetch at 0x40
        nxt();
        id_stall_i = 1'b1;
        do_reset(32'h0C, 1'b0);
        nxt();
        ack_man = 1'b1;
        #1 chk("t4_c1_pw", 32'(pc_write_o), 1);
        nxt();
        ack_man = 1'b0;
        flush_i = 1'b1;
        tgt     = 32'h40;
        #1;
        chk("t4_fl_pw", 32'(pc_write_o), 1);
        chk("t4_fl_valid", 32'(inst_valid_o), 1);
        chk("t4_fl_ipc", inst_pc_o, 32'h0C);
        chk("t4_fl_addr", mem_addr_o, 32'h10);
        nxt();
        flush_i = 1'b0;
        #1;
        chk("t4_c3_valid", 32'(inst_valid_o), 0);
        chk("t4_c3_req", 32'(mem_req_o), 1);
        chk("t4_c3_addr", mem_addr_o, 32'h10);
        chk("t4_c3_pw", 32'(pc_write_o), 0);
        nxt();
        ack_man = 1'b1;
        #1;
        chk("t4_c4_addr", mem_addr_o, 32'h10);
        chk("t4_c4_pw", 32'(pc_write_o), 0);
        nxt();
        ack_man = 1'b0;
        #1;
        chk("t4_c5_req", 32'(mem_req_o), 0);
        chk("t4_c5_valid", 32'(inst_valid_o), 0);
        chk("t4_c5_pc", pc_q, 32'h40);
        nxt(); #1;
        chk("t4_c6_req", 32'(mem_req_o), 1);
        chk("t4_c6_addr", mem_addr_o, 32'h40);
        id_stall_i = 1'b0;

        // Flush coincident with ack and pop
        nxt();
        do_reset(32'h100, 1'b1);
        nxt(); nxt();
        flush_i = 1'b1;
        tgt     = 32'h200;
        #1;
        chk("t5_fl_pw", 32'(pc_write_o), 1);
        chk("t5_fl_valid", 32'(inst_valid_o), 1);
        chk("t5_fl_ack", 32'(mem_ack_i), 1);
        nxt();
        flush_i = 1'b0;
        #1;
        chk("t5_c3_valid", 32'(inst_valid_o), 0);
        chk("t5_c3_req", 32'(mem_req_o), 0);
        chk("t5_c3_pw", 32'(pc_write_o), 0);
        nxt(); #1;
        chk("t5_c4_addr", mem_addr_o, 32'h200);

        // Asynchronous reset in the middle of a request
        nxt();
        id_stall_i = 1'b1;
        do_reset(32'h300, 1'b0);
        nxt();
        ack_man = 1'b1;
        nxt();
        #1 chk("t6_pw_pre", 32'(pc_write_o), 1);
        #2 rst_i = 1'b0;
        #1;
        chk("t6_req", 32'(mem_req_o), 0);
        chk("t6_valid", 32'(inst_valid_o), 0);
        chk("t6_pw", 32'(pc_write_o), 0);
        chk("t6_ipc", inst_pc_o, 32'h0);
        nxt();
        rst_i   = 1'b1;
        ack_man = 1'b0;
        #1 chk("t6_pc", pc_q, 32'h304);
        nxt(); #1;
        chk("t6_req2", 32'(mem_req_o), 1);
        chk("t6_addr2", mem_addr_o, 32'h304);
        id_stall_i = 1'b0;

        // Address wrap past the top of memory
        nxt();
        do_reset(32'hFFFF_FFFC, 1'b1);
        nxt(); #1;
        chk("t7_addr", mem_addr_o, 32'hFFFF_FFFC);
        nxt(); #1;
        chk("t7_wrap", mem_addr_o, 32'h0);
        chk("t7_ipc", inst_pc_o, 32'hFFFF_FFFC);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
